// File: rtl/clk_wiz_pkg.sv
// ---------------------------------------------------------------------------
// clk_wiz_pkg
// Shared constants and types for the clk_wiz_0 clock generator.
//   CNT_W            : width of a divider phase counter (DIV up to 256)
//   LOCK_W           : width of the saturating lock counter
//   DIV_MIN/DIV_MAX  : legal bounds of a division ratio
//   clamp_div()      : folds a division ratio into the legal range so that
//                      out-of-range parameters still elaborate cleanly
// ---------------------------------------------------------------------------
package clk_wiz_pkg;

    localparam int CNT_W   = 8;
    localparam int LOCK_W  = 16;
    localparam int DIV_MIN = 1;
    localparam int DIV_MAX = 256;

    typedef logic [CNT_W-1:0]  div_cnt_t;
    typedef logic [LOCK_W-1:0] lock_cnt_t;

    function automatic int clamp_div(input int div);
        if (div < DIV_MIN) begin
            return DIV_MIN;
        end
        if (div > DIV_MAX) begin
            return DIV_MAX;
        end
        return div;
    endfunction

endpackage

// File: rtl/clk_wiz_0_clk_div.sv
// ---------------------------------------------------------------------------
// clk_div
// Integer clock divider producing one output clock from the reference clock.
//   DIV = 1 : clk_o = clk AND run, where run rises on the first edge after
//             reset release (a glitch on async reset assertion is accepted).
//   DIV >= 2: phase counter 0..DIV-1; clk_o is registered as cnt < DIV/2,
//             so the first rising edge of clk_o lands on the first clk edge
//             after release and the period is exactly DIV input cycles.
// Ports:
//   clk   in  reference clock (rising edge only)
//   rst_n in  asynchronous active-low reset
//   clk_o out divided clock
// ---------------------------------------------------------------------------
module clk_div
    import clk_wiz_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_o
);

    localparam int DIV_C = clamp_div(DIV);

    generate
        if (DIV_C == DIV_MIN) begin : g_bypass
            logic r_run;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_run <= 1'b0;
                end else begin
                    r_run <= 1'b1;
                end
            end

            // Gating with run keeps the output low during reset while passing
            // the reference straight through once running.
            assign clk_o = clk & r_run;
        end else begin : g_count
            localparam div_cnt_t CNT_LAST = div_cnt_t'(DIV_C - 1);
            localparam div_cnt_t CNT_HIGH = div_cnt_t'(DIV_C / 2);

            div_cnt_t r_cnt;
            logic     r_clk;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                end else begin
                    // Decode the current phase before stepping, so phase 0
                    // (the reset value) produces the high level on edge 1.
                    r_clk <= (r_cnt < CNT_HIGH);
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + div_cnt_t'(1);
                end
            end

            assign clk_o = r_clk;
        end
    endgenerate

endmodule

// File: rtl/clk_wiz_0.sv
// ---------------------------------------------------------------------------
// clk_wiz_0
// Counter-based clock generator: one or two divided clocks from clk_in1 plus
// a lock indicator that rises a fixed number of edges after reset release.
// Optional feature macro: CLK_WIZ_CLK_OUT2_EN
//   defined   -> clk_out2 is a second divided clock (ratio DIV2)
//   undefined -> clk_out2 is tied to 0 and no second divider is built
// Parameters:
//   DIV1        clk_out1 division ratio (1..256)
//   DIV2        clk_out2 division ratio (1..256)
//   LOCK_CYCLES clk_in1 edges from reset release to locked (1..65535)
// Ports:
//   clk_in1  in  reference clock
//   resetn   in  asynchronous active-low reset
//   clk_out1 out divided clock for the memory controller
//   clk_out2 out second divided clock (or constant 0)
//   locked   out high once outputs are stable, held until reset
// ---------------------------------------------------------------------------
module clk_wiz_0
    import clk_wiz_pkg::*;
#(
    parameter int DIV1        = 2,
    parameter int DIV2        = 4,
    parameter int LOCK_CYCLES = 64
) (
    input  logic clk_in1,
    input  logic resetn,
    output logic clk_out1,
    output logic clk_out2,
    output logic locked
);

    // Both dividers share the reset release edge, so their phase counters
    // start together and stay rising-edge aligned at every common multiple.
    clk_div #(
        .DIV(DIV1)
    ) u_div1 (
        .clk   (clk_in1),
        .rst_n (resetn),
        .clk_o (clk_out1)
    );

`ifdef CLK_WIZ_CLK_OUT2_EN
    clk_div #(
        .DIV(DIV2)
    ) u_div2 (
        .clk   (clk_in1),
        .rst_n (resetn),
        .clk_o (clk_out2)
    );
`else
    assign clk_out2 = 1'b0;
`endif

    // Lock counter: saturating edge count since release. locked is set when
    // the count is about to reach LOCK_CYCLES, i.e. on that very edge.
    localparam lock_cnt_t LOCK_LAST = lock_cnt_t'(LOCK_CYCLES - 1);
    localparam lock_cnt_t LOCK_SAT  = '1;

    lock_cnt_t r_lock_cnt;
    logic      r_locked;

    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (r_lock_cnt != LOCK_SAT) begin
                r_lock_cnt <= r_lock_cnt + lock_cnt_t'(1);
            end
            if (r_lock_cnt == LOCK_LAST) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign locked = r_locked;

endmodule

// File: tb/tb_clk_wiz_0.sv
// ---------------------------------------------------------------------------
// tb_clk_wiz_0
// Three clk_wiz_0 instances with different ratios share one clock and reset:
//   u0: DIV1=2, DIV2=4, LOCK_CYCLES=64
//   u1: DIV1=3, DIV2=5, LOCK_CYCLES=10
//   u2: DIV1=1, DIV2=3, LOCK_CYCLES=1
// Expected values come from a phase model: after k edges since release, a
// DIV>=2 output is high iff ((k-1) mod DIV) < DIV/2; a DIV=1 output follows
// the clock once k>=1; locked is k >= LOCK_CYCLES.
// ---------------------------------------------------------------------------
module tb_clk_wiz_0;

`ifdef CLK_WIZ_CLK_OUT2_EN
    localparam bit OUT2_EN = 1'b1;
`else
    localparam bit OUT2_EN = 1'b0;
`endif

    logic clk_in1 = 1'b0;
    logic resetn  = 1'b0;

    logic u0_o1, u0_o2, u0_lk;
    logic u1_o1, u1_o2, u1_lk;
    logic u2_o1, u2_o2, u2_lk;

    always #5 clk_in1 = ~clk_in1;

    clk_wiz_0 #(.DIV1(2), .DIV2(4), .LOCK_CYCLES(64)) u0 (
        .clk_in1 (clk_in1), .resetn (resetn),
        .clk_out1(u0_o1), .clk_out2(u0_o2), .locked(u0_lk)
    );
    clk_wiz_0 #(.DIV1(3), .DIV2(5), .LOCK_CYCLES(10)) u1 (
        .clk_in1 (clk_in1), .resetn (resetn),
        .clk_out1(u1_o1), .clk_out2(u1_o2), .locked(u1_lk)
    );
    clk_wiz_0 #(.DIV1(1), .DIV2(3), .LOCK_CYCLES(1)) u2 (
        .clk_in1 (clk_in1), .resetn (resetn),
        .clk_out1(u2_o1), .clk_out2(u2_o2), .locked(u2_lk)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // rising edges seen since the last reset release

    typedef struct {
        int k;
        bit u0o1;
        bit u0o2;
        bit u0lk;
        bit u1o1;
        bit u2o1;
    } vec_t;

    vec_t tbl[9];

    function automatic bit exp_div(input int div, input int kk, input bit rstn, input bit clkv);
        if (!rstn || kk == 0) return 1'b0;
        if (div == 1) return clkv;
        return ((kk - 1) % div) < (div / 2);
    endfunction

    task automatic cmp(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t k=%0d: got %b, expected %b", name, $time, k, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        cmp({tag, " u0.clk_out1"}, u0_o1, exp_div(2, k, resetn, clk_in1));
        cmp({tag, " u0.clk_out2"}, u0_o2, OUT2_EN ? exp_div(4, k, resetn, clk_in1) : 1'b0);
        cmp({tag, " u0.locked"},   u0_lk, resetn && k >= 64);
        cmp({tag, " u1.clk_out1"}, u1_o1, exp_div(3, k, resetn, clk_in1));
        cmp({tag, " u1.clk_out2"}, u1_o2, OUT2_EN ? exp_div(5, k, resetn, clk_in1) : 1'b0);
        cmp({tag, " u1.locked"},   u1_lk, resetn && k >= 10);
        cmp({tag, " u2.clk_out1"}, u2_o1, exp_div(1, k, resetn, clk_in1));
        cmp({tag, " u2.clk_out2"}, u2_o2, OUT2_EN ? exp_div(3, k, resetn, clk_in1) : 1'b0);
        cmp({tag, " u2.locked"},   u2_lk, resetn && k >= 1);
    endtask

    task automatic rise_half(input string tag);
        @(posedge clk_in1);
        if (resetn) k++;
        #1;
        model_check({tag, "/r"});
    endtask

    task automatic fall_half(input string tag);
        @(negedge clk_in1);
        #1;
        model_check({tag, "/f"});
    endtask

    initial begin
        tbl[0] = '{k:1,  u0o1:1, u0o2:1, u0lk:0, u1o1:1, u2o1:1};
        tbl[1] = '{k:2,  u0o1:0, u0o2:1, u0lk:0, u1o1:0, u2o1:1};
        tbl[2] = '{k:3,  u0o1:1, u0o2:0, u0lk:0, u1o1:0, u2o1:1};
        tbl[3] = '{k:4,  u0o1:0, u0o2:0, u0lk:0, u1o1:1, u2o1:1};
        tbl[4] = '{k:5,  u0o1:1, u0o2:1, u0lk:0, u1o1:0, u2o1:1};
        tbl[5] = '{k:9,  u0o1:1, u0o2:1, u0lk:0, u1o1:0, u2o1:1};
        tbl[6] = '{k:63, u0o1:1, u0o2:0, u0lk:0, u1o1:0, u2o1:1};
        tbl[7] = '{k:64, u0o1:0, u0o2:0, u0lk:1, u1o1:1, u2o1:1};
        tbl[8] = '{k:65, u0o1:1, u0o2:1, u0lk:1, u1o1:0, u2o1:1};

        // Reset state, including the DIV=1 output while the clock is high.
        for (int i = 0; i < 4; i++) begin
            rise_half("reset");
            fall_half("reset");
        end

        // Release between edges.
        resetn = 1'b1;
        k = 0;

        // Directed table after release.
        for (int i = 0; i < 9; i++) begin
            do begin
                rise_half("tbl");
                if (k != tbl[i].k) fall_half("tbl");
            end while (k < tbl[i].k);
            $display("vec k=%0d u0=%b%b%b u1=%b u2=%b", k, u0_o1, u0_o2, u0_lk, u1_o1, u2_o1);
            cmp("tbl u0.clk_out1", u0_o1, tbl[i].u0o1);
            cmp("tbl u0.clk_out2", u0_o2, OUT2_EN ? tbl[i].u0o2 : 1'b0);
            cmp("tbl u0.locked",   u0_lk, tbl[i].u0lk);
            cmp("tbl u1.clk_out1", u1_o1, tbl[i].u1o1);
            cmp("tbl u2.clk_out1", u2_o1, tbl[i].u2o1);
            fall_half("tbl");
        end

        // Reset pulsed mid-operation right after edge 100: outputs drop at once.
        while (k < 99) begin
            rise_half("run");
            fall_half("run");
        end
        rise_half("run");
        #1 resetn = 1'b0;
        k = 0;
        #1;
        $display("midreset k=0 u0=%b%b%b u2=%b%b", u0_o1, u0_o2, u0_lk, u2_o1, u2_lk);
        cmp("midreset u0.clk_out1", u0_o1, 1'b0);
        cmp("midreset u0.locked",   u0_lk, 1'b0);
        cmp("midreset u2.clk_out1", u2_o1, 1'b0);
        cmp("midreset u2.locked",   u2_lk, 1'b0);
        fall_half("midreset");
        rise_half("midreset");
        fall_half("midreset");
        resetn = 1'b1;

        // Relock must take exactly 64 edges again.
        for (int i = 1; i <= 64; i++) begin
            rise_half("relock");
            if (i == 63) cmp("relock locked@63", u0_lk, 1'b0);
            if (i == 64) cmp("relock locked@64", u0_lk, 1'b1);
            fall_half("relock");
        end

        // Randomized reset activity checked against the phase model.
        for (int i = 0; i < 2500; i++) begin
            rise_half("rand");
            fall_half("rand");
            if (resetn && $urandom_range(0, 149) == 0) begin
                #($urandom_range(0, 3));
                resetn = 1'b0;
                k = 0;
                #0.5;
                model_check("rand/assert");
            end else if (!resetn && $urandom_range(0, 3) == 0) begin
                resetn = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_wiz_0.md
CLK_WIZ_0 -- requirements
Module: clk_wiz_0

Interface
REQ-001 SHALL have parameter DIV1, default 2: clk_out1 division ratio from clk_in1, legal range 1..256.
REQ-002 SHALL have parameter DIV2, default 4: clk_out2 division ratio, legal range 1..256.
REQ-003 SHALL have parameter LOCK_CYCLES, default 64: clk_in1 rising edges from reset release to locked, legal range 1..65535.
REQ-004 SHALL have port clk_in1, input, 1 bit: sole reference clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset.
REQ-006 SHALL have port clk_out1, output, 1 bit: divided clock feeding the memory controller.
REQ-007 SHALL have port clk_out2, output, 1 bit: divided reference clock; present only per REQ-021.
REQ-008 SHALL have port locked, output, 1 bit: high once outputs are stable.
REQ-009 SHALL use one clock and an asynchronous, active-low reset: clk_in1 is the clock and resetn is the reset.

Function
REQ-010 SHALL clock all registers on the rising edge of clk_in1; no other edge or clock is used.
REQ-011 SHALL, for each output with DIV ≥ 2, keep a counter cnt that starts at 0 and steps 0..DIV-1, wrapping to 0 after DIV-1.
REQ-012 SHALL register that output as (cnt < DIV/2, integer division), so each output period is exactly DIV input cycles.
  - Even DIV: 50 % duty.
  - Odd DIV: high floor(DIV/2) cycles, low ceil(DIV/2) cycles.
REQ-013 SHALL make the first output rising edge occur on the first clk_in1 rising edge after resetn deasserts.
REQ-014 SHALL keep clk_out1 and clk_out2 rising-edge aligned at every common multiple of DIV1 and DIV2 input cycles after reset release.
REQ-015 SHALL, for DIV = 1, drive the output as clk_in1 AND run.
  - run is a register set on the first clk_in1 rising edge after release.
  - A glitch on asynchronous reset assertion is accepted.
REQ-016 SHALL count clk_in1 rising edges after release in a saturating lock counter, 16 bits wide.
REQ-017 SHALL set locked on the LOCK_CYCLES-th rising edge after release and hold it until reset.
REQ-018 SHALL ignore out-of-range parameters; behaviour for them is undefined and the bench does not cover them.

Reset
REQ-019 SHALL, while resetn is low (asynchronously, including mid-operation):
  - force clk_out1, clk_out2 and locked to 0;
  - clear all counters and run.
REQ-020 SHALL, after resetn rises, restart exactly as from power-up, with no memory of the prior phase.

Configuration
REQ-021 SHALL compile the second output under macro CLK_WIZ_CLK_OUT2_EN.
  - Defined: clk_out2 is generated per REQ-011..REQ-015.
  - Undefined: the clk_out2 port still exists but is tied to constant 0, and no divider logic for it is built.

Structure
REQ-022 SHALL place the counter width, the lock counter width (16) and the legal DIV bounds (1, 256) as constants in package clk_wiz_pkg.
REQ-023 SHALL implement each output with one sub-module clk_div (parameter DIV; ports clk, rst_n, clk_o), instantiated once or twice.
REQ-024 SHALL keep lock logic in the top module.

Verification
REQ-025 SHALL cover these directed scenarios:
  - DIV1=2, LOCK_CYCLES=64: resetn released → clk_out1 high on edge 1, toggles every edge; locked rises on edge 64.
  - DIV1=3 → repeating pattern high 1, low 2 cycles; period 3.
  - DIV1=2, DIV2=4 with CLK_WIZ_CLK_OUT2_EN → both outputs rise together on edges 1, 5, 9; clk_out2 high 2, low 2.
  - resetn pulsed low at edge 100 → all outputs 0 immediately; after release, locked again after exactly 64 edges.
  - DIV1=1 → clk_out1 equals clk_in1 from the first edge after release; 0 during reset.
  - Macro undefined → clk_out2 constantly 0 across 1000 cycles.
